// File: rtl/out_module.sv
// Decimal display output peripheral: latches a word on out_en, converts it to BCD by
// shift-add-3 and drives active-low 7-segment digits. Optional macro: OUT_LEADING_ZERO_BLANK_EN.
module out_module #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIGITS     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    out_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    signed_mode,
    output logic [7*DIGITS-1:0]     hex_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned CONV_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int unsigned BCD_W       = 4 * CONV_DIGITS;
    localparam int unsigned CNT_W       = $clog2(DATA_WIDTH);
    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [6:0]  SEG_DASH    = 7'h3F;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mag;
    logic                  neg;
    logic [BCD_W-1:0]      bcd;
    logic [BCD_W-1:0]      bcdAdj;
    logic [CNT_W-1:0]      bitCnt;
    logic                  pendValid;
    logic [DATA_WIDTH-1:0] pendData;
    logic                  pendSigned;
    logic                  fits;
    logic [7*DIGITS-1:0]   hexNext;

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0:    segOf = 7'h40;
            4'd1:    segOf = 7'h79;
            4'd2:    segOf = 7'h24;
            4'd3:    segOf = 7'h30;
            4'd4:    segOf = 7'h19;
            4'd5:    segOf = 7'h12;
            4'd6:    segOf = 7'h02;
            4'd7:    segOf = 7'h78;
            4'd8:    segOf = 7'h00;
            4'd9:    segOf = 7'h10;
            default: segOf = SEG_BLANK;
        endcase
    endfunction

    // Returns {neg, magnitude}; the magnitude is unsigned so the most negative value stays exact.
    function automatic logic [DATA_WIDTH:0] captureOf(input logic [DATA_WIDTH-1:0] d, input logic s);
        logic isNeg;
        isNeg = s & d[DATA_WIDTH-1];
        captureOf = {isNeg, isNeg ? DATA_WIDTH'(-d) : d};
    endfunction

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        bcdAdj = bcd;
        for (int i = 0; i < int'(CONV_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef OUT_LEADING_ZERO_BLANK_EN
    int msd;
`endif

    // Fit test and segment image for the finished BCD value
    always_comb begin
        fits    = 1'b1;
        hexNext = '1;
        for (int i = 0; i < int'(CONV_DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd0 && i >= int'(DIGITS) - (neg ? 1 : 0))
                fits = 1'b0;
        end
`ifdef OUT_LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                msd = i;
        end
`endif
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (!fits)
                hexNext[7*k +: 7] = SEG_DASH;
            else begin
                hexNext[7*k +: 7] = segOf(bcd[4*k +: 4]);
`ifdef OUT_LEADING_ZERO_BLANK_EN
                if (k > msd)
                    hexNext[7*k +: 7] = (neg && k == msd + 1) ? SEG_DASH : SEG_BLANK;
`else
                if (neg && k == int'(DIGITS) - 1)
                    hexNext[7*k +: 7] = SEG_DASH;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hex_out    <= '1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            pendValid  <= 1'b0;
            pendData   <= '0;
            pendSigned <= 1'b0;
            mag        <= '0;
            neg        <= 1'b0;
            bcd        <= '0;
            bitCnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A fresh strobe beats a leftover slot entry (newest wins)
                    if (out_en || pendValid) begin
                        {neg, mag} <= out_en ? captureOf(data_in, signed_mode)
                                             : captureOf(pendData, pendSigned);
                        pendValid  <= 1'b0;
                        bcd        <= '0;
                        bitCnt     <= '0;
                        busy       <= 1'b1;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd    <= {bcdAdj[BCD_W-2:0], mag[DATA_WIDTH-1]};
                    mag    <= {mag[DATA_WIDTH-2:0], 1'b0};
                    bitCnt <= bitCnt + CNT_W'(1);
                    if (bitCnt == CNT_W'(DATA_WIDTH - 1))
                        state <= UPDATE;
                    if (out_en) begin
                        pendValid  <= 1'b1;
                        pendData   <= data_in;
                        pendSigned <= signed_mode;
                    end
                end
                UPDATE: begin
                    hex_out  <= hexNext;
                    overflow <= ~fits;
                    if (pendValid) begin
                        {neg, mag} <= captureOf(pendData, pendSigned);
                        pendValid  <= 1'b0;
                        bcd        <= '0;
                        bitCnt     <= '0;
                        state      <= CONVERT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    // Slot read above sees the old entry; a same-cycle strobe refills it
                    if (out_en) begin
                        pendValid  <= 1'b1;
                        pendData   <= data_in;
                        pendSigned <= signed_mode;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_module.sv
// Directed bench for out_module: table of single conversions plus back-to-back and reset sequences.
module tb_out_module;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] DS = 7'h3F, BK = 7'h7F;
    localparam logic [55:0] ALL_DASH  = {DS, DS, DS, DS, DS, DS, DS, DS};
    localparam logic [55:0] ALL_BLANK = {BK, BK, BK, BK, BK, BK, BK, BK};
`ifdef OUT_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_BUILD = 1'b1;
`else
    localparam bit BLANK_BUILD = 1'b0;
`endif
    localparam int LATENCY = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        out_en = 1'b0;
    logic [31:0] data_in = '0;
    logic        signed_mode = 1'b0;
    logic [55:0] hex_out;
    logic        busy;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [55:0] hex;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    out_module dut (
        .clock(clock), .reset(reset), .out_en(out_en), .data_in(data_in),
        .signed_mode(signed_mode), .hex_out(hex_out), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        out_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One-cycle strobe; returns just after the sampling edge
    task automatic strobe(input logic [31:0] d, input logic s);
        @(negedge clock);
        out_en = 1'b1;
        data_in = d;
        signed_mode = s;
        @(posedge clock);
        #1;
        out_en = 1'b0;
        check("busy_after_strobe", 64'(busy), 64'(1));
    endtask

    // Count edges until busy falls, bounded
    task automatic waitIdle(output int cnt);
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (busy && cnt < 200);
    endtask

    task automatic runVec(input string name, input logic [31:0] d, input logic s,
                          input logic [55:0] eh, input logic eo);
        int cnt;
        strobe(d, s);
        waitIdle(cnt);
        check({name, "_latency"}, 64'(cnt), 64'(LATENCY));
        check({name, "_hex"}, 64'(hex_out), 64'(eh));
        check({name, "_ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{32'h0000007B, 1'b0, BLANK_BUILD ? {BK, BK, BK, BK, BK, S1, S2, S3}
                                                    : {S0, S0, S0, S0, S0, S1, S2, S3}, 1'b0};
        vecs[1]  = '{32'hFFFFFF85, 1'b1, BLANK_BUILD ? {BK, BK, BK, BK, DS, S1, S2, S3}
                                                    : {DS, S0, S0, S0, S0, S1, S2, S3}, 1'b0};
        vecs[2]  = '{32'hFFFFFF85, 1'b0, ALL_DASH, 1'b1};
        vecs[3]  = '{32'h05F5E0FF, 1'b0, {S9, S9, S9, S9, S9, S9, S9, S9}, 1'b0};
        vecs[4]  = '{32'h05F5E100, 1'b0, ALL_DASH, 1'b1};
        vecs[5]  = '{32'hFF676981, 1'b1, {DS, S9, S9, S9, S9, S9, S9, S9}, 1'b0};
        vecs[6]  = '{32'hFF676980, 1'b1, ALL_DASH, 1'b1};
        vecs[7]  = '{32'h00BC614E, 1'b0, {S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0};
        vecs[8]  = '{32'h80000000, 1'b1, ALL_DASH, 1'b1};
        vecs[9]  = '{32'h00000000, 1'b1, BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, BK, S0}
                                                    : {S0, S0, S0, S0, S0, S0, S0, S0}, 1'b0};
        vecs[10] = '{32'h80000000, 1'b0, ALL_DASH, 1'b1};
        vecs[11] = '{32'hFFFFFFFF, 1'b1, BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, DS, S1}
                                                    : {DS, S0, S0, S0, S0, S0, S0, S1}, 1'b0};

        doReset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("reset_hex", 64'(hex_out), 64'(ALL_BLANK));
            check("reset_busy", 64'(busy), 64'(0));
            check("reset_ovf", 64'(overflow), 64'(0));
        end

        for (int i = 0; i < 12; i++)
            runVec($sformatf("vec%0d", i), vecs[i].data, vecs[i].sgn, vecs[i].hex, vecs[i].ovf);

        // Back-to-back: 5, then 6 and 7 while busy; 6 is overwritten by 7
        strobe(32'd5, 1'b0);
        repeat (3) @(posedge clock);
        strobe(32'd6, 1'b0);
        repeat (3) @(posedge clock);
        strobe(32'd7, 1'b0);
        repeat (LATENCY - 8) @(posedge clock);
        #1;
        check("b2b_first_hex", 64'(hex_out),
              64'(BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, BK, S5} : {S0, S0, S0, S0, S0, S0, S0, S5}));
        check("b2b_busy_held", 64'(busy), 64'(1));
        waitIdle(cnt);
        check("b2b_second_latency", 64'(cnt), 64'(LATENCY));
        check("b2b_second_hex", 64'(hex_out),
              64'(BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, BK, S7} : {S0, S0, S0, S0, S0, S0, S0, S7}));
        repeat (40) @(posedge clock);
        #1;
        check("b2b_no_third", 64'(busy), 64'(0));
        check("b2b_hex_held", 64'(hex_out),
              64'(BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, BK, S7} : {S0, S0, S0, S0, S0, S0, S0, S7}));

        // Reset mid-conversion with a pending entry queued
        strobe(32'd12345, 1'b0);
        repeat (4) @(posedge clock);
        strobe(32'd99, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_hex", 64'(hex_out), 64'(ALL_BLANK));
        check("midreset_ovf", 64'(overflow), 64'(0));
        repeat (50) @(posedge clock);
        #1;
        check("midreset_pend_cleared_busy", 64'(busy), 64'(0));
        check("midreset_pend_cleared_hex", 64'(hex_out), 64'(ALL_BLANK));
        runVec("after_reset_42", 32'd42, 1'b0,
               BLANK_BUILD ? {BK, BK, BK, BK, BK, BK, S4, S2} : {S0, S0, S0, S0, S0, S0, S4, S2}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
